// File: rtl/multicycle_ctrl_if.sv
// Memory-port handshake between the multicycle control unit and the unified memory.
// The controller is the master: it raises the request, the memory answers with mem_ready.
interface multicycle_ctrl_if;
  logic mem_req;
  logic MemWrite;
  logic AdrSrc;
  logic mem_ready;

  modport master (output mem_req, output MemWrite, output AdrSrc, input mem_ready);
  modport slave  (input mem_req, input MemWrite, input AdrSrc, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control FSM: one state register sequences every datapath
// strobe and mux select, with a valid/ready request to the shared memory port.
module multicycle_ctrl (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              zero,
  multicycle_ctrl_if.master mem,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic [1:0]        ALUsrcA,
  output logic [1:0]        ALUsrcB,
  output logic [2:0]        ALUctrl,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ImmSrc,
  output logic              retire,
  output logic              trap
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state;
  state_t     decode_next;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_f3_ok;
  logic       r_f7_ok;
  logic [2:0] alu_op;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Opcode dispatch plus the funct-field legality checks that divert to TRAP.
  always_comb begin
    alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                (funct3 == 3'b110) || (funct3 == 3'b111);
    r_f7_ok   = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && (funct3 == 3'b000));
    case (opcode)
      OP_LOAD, OP_STORE: decode_next = MEMADR;
      OP_R:              decode_next = (alu_f3_ok && r_f7_ok) ? EXECR : TRAP;
      OP_I:              decode_next = alu_f3_ok ? EXECI : TRAP;
      OP_BR:             decode_next = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
      OP_JAL:            decode_next = JAL;
      default:           decode_next = TRAP;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b010:  alu_op = ALU_SLT;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ((opcode == OP_R) && instr[30]) ? ALU_SUB : ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (mem.mem_ready) state <= DECODE;
        DECODE:   state <= decode_next;
        MEMADR:   state <= (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem.mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem.mem_ready) state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        JAL:      state <= ALUWB;
        TRAP:     state <= TRAP;
        default:  state <= FETCH;
      endcase
    end
  end

  // Outputs are gated by reset so they fall asynchronously, even mid-request.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.MemWrite = 1'b0;
    mem.AdrSrc   = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUsrcA      = 2'b00;
    ALUsrcB      = 2'b00;
    ALUctrl      = ALU_ADD;
    ResultSrc    = 2'b00;
    ImmSrc       = 2'b00;
    retire       = 1'b0;
    trap         = 1'b0;
    if (rst) begin
      case (state)
        FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUsrcB   = 2'b10;
            ResultSrc = 2'b10;
          end
        end
        DECODE: begin
          ALUsrcA = 2'b01;
          ALUsrcB = 2'b01;
          ImmSrc  = 2'b10;
        end
        MEMADR: begin
          ALUsrcA = 2'b10;
          ALUsrcB = 2'b01;
          ImmSrc  = (opcode == OP_STORE) ? 2'b01 : 2'b00;
        end
        MEMREAD: begin
          mem.mem_req = 1'b1;
          mem.AdrSrc  = 1'b1;
        end
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
          retire    = 1'b1;
        end
        MEMWRITE: begin
          mem.mem_req  = 1'b1;
          mem.MemWrite = 1'b1;
          mem.AdrSrc   = 1'b1;
          retire       = mem.mem_ready;
        end
        EXECR: begin
          ALUsrcA = 2'b10;
          ALUctrl = alu_op;
        end
        EXECI: begin
          ALUsrcA = 2'b10;
          ALUsrcB = 2'b01;
          ALUctrl = alu_op;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        BRANCH: begin
          ALUsrcA = 2'b10;
          ALUctrl = ALU_SUB;
          PCWrite = funct3[0] ? !zero : zero;
          retire  = 1'b1;
        end
        JAL: begin
          ALUsrcA = 2'b01;
          ALUsrcB = 2'b10;
          PCWrite = 1'b1;
        end
        TRAP:    trap = 1'b1;
        default: trap = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Finite-state control unit that sequences the shared RV32I datapath (register file + ALU, immediate extender, PC register, unified instruction/data memory) over multiple cycles per instruction. It replaces the single-cycle combinational control decode. Every datapath strobe and mux select is driven from one state register. A valid/ready-style request to the single memory port allows variable memory latency.

## Interface
Parameters: none. The opcode set is fixed (RV32I subset below).

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- instr  in  32  current instruction, from the IR (valid from DECODE onward)
- zero  in  1  ALU zero flag, combinational from the datapath
- mem_ready  in  1  memory completes the pending access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  request is a store
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load the IR and latch OldPC
- PCWrite  out  1  load the PC from Result
- RegWrite  out  1  write Result to rd
- ALUsrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- ALUsrcB  out  2  00 = rs2 data, 01 = ImmOp, 10 = constant 4
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ResultSrc  out  2  00 = ALUOut register, 01 = memory data register, 10 = ALU result
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- retire  out  1  one-cycle pulse on the final cycle of each completed instruction
- trap  out  1  illegal instruction detected; sticky until reset

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP. Every output not listed for a state is 0.

- **FETCH:** mem_req=1, AdrSrc=0.
  - On mem_ready: IRWrite=1, ALUsrcA=00, ALUsrcB=10, ALUctrl=add, ResultSrc=10, PCWrite=1, go to DECODE.
  - Otherwise stay in FETCH with no strobes.
- **DECODE:** ALUsrcA=01, ALUsrcB=01, ImmSrc=10, ALUctrl=add (precomputes the branch target into ALUOut). Next state by opcode = instr[6:0]:
  - 0000011 load / 0100011 store -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> TRAP
- **Additional DECODE traps:**
  - Branch with funct3 not in {000, 001}.
  - ALU op with funct3 not in {000, 010, 110, 111}.
  - R-type with instr[31:25] not in {0000000, 0100000}.
  - R-type with instr[31:25]=0100000 and funct3≠000.
- **MEMADR:** ALUsrcA=10, ALUsrcB=01, ALUctrl=add, ImmSrc=00 for load or 01 for store. Go to MEMREAD (load) or MEMWRITE (store).
- **MEMREAD:** mem_req=1, AdrSrc=1, ResultSrc=00. On mem_ready go to MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1, retire=1, go to FETCH.
- **MEMWRITE:** mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00. On mem_ready: retire=1, go to FETCH.
- **EXECR:** ALUsrcA=10, ALUsrcB=00, ALUctrl from funct decode. Go to ALUWB.
- **EXECI:** ALUsrcA=10, ALUsrcB=01, ImmSrc=00, ALUctrl from funct decode. Go to ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1, retire=1, go to FETCH.
- **BRANCH:** ALUsrcA=10, ALUsrcB=00, ALUctrl=sub, ResultSrc=00.
  - PCWrite = zero for beq (funct3 000), !zero for bne (funct3 001).
  - retire=1, go to FETCH.
- **JAL:** ALUsrcA=01, ALUsrcB=10, ALUctrl=add, ResultSrc=00, PCWrite=1. Go to ALUWB (writes rd = OldPC+4).
- **TRAP:** trap=1, all other outputs 0, no exit except reset.
- **Funct decode:**
  - funct3 000: add, or sub when R-type and instr[30]=1.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - I-type funct3 000 ignores instr[30].

## Timing
- **Reset:** while rst=0, state=FETCH and every output is 0, asynchronously. The first request (mem_req=1 in FETCH) appears in the first cycle after rst rises.
- **Output timing:**
  - Outputs are combinational from the state register plus mem_ready/zero/instr.
  - The state register updates on the rising edge of clk.
- **Memory handshake:**
  - mem_req, AdrSrc and MemWrite stay constant from request until the cycle in which mem_ready=1. That cycle completes the transfer.
  - mem_ready while mem_req=0 is ignored.
  - No back-to-back request is issued without an intervening non-memory state, except MEMWRITE -> FETCH.
- **Minimum cycle counts with zero-wait memory** (mem_ready=1 in the first request cycle), FETCH through retire:
  - branch 3
  - R/I-ALU 4
  - store 4
  - jal 4
  - load 5
- Each memory wait cycle adds exactly one cycle.
- retire and IRWrite are single-cycle pulses. At most one retire occurs per instruction; TRAP never retires.
- **Reset mid-instruction** (including during a pending mem_req): outputs drop to 0 immediately and no write strobe fires. Execution restarts in FETCH.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with mem_ready=1 -> all outputs 0. First cycle after release: mem_req=1, AdrSrc=0.
- **add x3,x1,x2** (0x002081B3) with mem_ready tied 1 -> states FETCH, DECODE, EXECR, ALUWB:
  - EXECR: ALUctrl=000.
  - ALUWB: RegWrite=1 and retire=1 in cycle 4.
  - sub (0x402081B3) gives ALUctrl=001.
- **lw** (0x0000A183) with mem_ready low for 3 cycles in MEMREAD:
  - mem_req=1, AdrSrc=1 held for 4 cycles.
  - MEMWB then asserts ResultSrc=01, RegWrite=1; total 8 cycles.
- **beq** (0x00208463):
  - zero=1 -> PCWrite=1 in BRANCH.
  - zero=0 -> PCWrite=0.
  - retire=1 in both cases, 3 cycles each.
- **Illegal opcode** 0x0000007F -> TRAP after DECODE. trap=1 holds for 10 cycles, no retire, mem_req=0; clears only on reset.
- **sw** (0x0020A023) with reset asserted during the second MEMWRITE wait cycle -> MemWrite and mem_req fall to 0 in the same cycle. After release: FETCH, no retire pulse.
